// File: rtl/lifo_drain.sv
// rtl/lifo_drain.sv - drains a burst of words from a LIFO into a 2-entry ready/valid output buffer
module lifo_drain #(
  parameter int BITWIDTH = 5,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DEPTH:0]      len,
  output logic                busy,
  output logic                done,
  output logic                underrun,
  input  logic                lifo_empty,
  input  logic [BITWIDTH-1:0] lifo_dout,
  output logic                lifo_ren,
  output logic [BITWIDTH-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_POP   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [DEPTH:0] REM_ONE  = (DEPTH+1)'(1);
  localparam logic [DEPTH:0] REM_ZERO = '0;

  state_t              state_q, state_d;
  logic [DEPTH:0]      remaining_q, remaining_d;
  logic                underrun_q, underrun_d;
  logic                done_q, done_d;

  // Output buffer: two slots addressed by 1-bit pointers, count 0..2
  logic [BITWIDTH-1:0] buf_data_q [2];
  logic [1:0]          buf_last_q;
  logic                wr_ptr_q, rd_ptr_q;
  logic [1:0]          cnt_q, cnt_d;

  logic                push, pop;

  assign push  = lifo_ren;
  assign pop   = out_valid & out_ready;
  assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-value logic for the burst control
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    underrun_d  = underrun_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          underrun_d = 1'b0;
          if (len != REM_ZERO) begin
            remaining_d = len;
            state_d     = S_POP;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_POP: begin
        if (lifo_ren) begin
          remaining_d = remaining_q - REM_ONE;
          if (remaining_q == REM_ONE) begin
            state_d = S_FLUSH;
          end
        end else if (lifo_empty && (remaining_q != REM_ZERO)) begin
          underrun_d = 1'b1;
          state_d    = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Leave as soon as the last buffered word is handed off, so done
        // lines up with busy dropping.
        if (cnt_d == 2'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; everything is forced low while reset is held
  always_comb begin
    busy      = (state_q != S_IDLE) & ~rst;
    done      = done_q & ~rst;
    underrun  = underrun_q & ~rst;
    lifo_ren  = (state_q == S_POP) & ~lifo_empty & (remaining_q != REM_ZERO)
              & (cnt_q < 2'd2) & ~rst;
    out_valid = (cnt_q != 2'd0) & ~rst;
    out_data  = out_valid ? buf_data_q[rd_ptr_q] : '0;
    out_last  = out_valid ? buf_last_q[rd_ptr_q] : 1'b0;
  end

  // Burst counters, flags and buffer bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q <= '0;
      underrun_q  <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      underrun_q  <= underrun_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Buffer storage; contents only matter while the slot is counted as valid
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data_q[wr_ptr_q] <= lifo_dout;
      buf_last_q[wr_ptr_q] <= (remaining_q == REM_ONE);
    end
  end

endmodule

// File: tb/tb_lifo_drain.sv
// tb/tb_lifo_drain.sv - scoreboard bench for lifo_drain against a behavioural LIFO
module tb_lifo_drain;

  localparam int BW = 5;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DP:0]   len;
  logic          busy, done, underrun;
  logic          lifo_empty;
  logic [BW-1:0] lifo_dout;
  logic          lifo_ren;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  always #5 clk = ~clk;

  lifo_drain #(.BITWIDTH(BW), .DEPTH(DP)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun),
    .lifo_empty (lifo_empty),
    .lifo_dout  (lifo_dout),
    .lifo_ren   (lifo_ren),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
  );

  // Behavioural LIFO
  logic [BW-1:0] stack_mem [0:31];
  int            sp = 0;
  logic          lifo_clr;
  logic          push_en;
  logic [BW-1:0] push_data;

  assign lifo_empty = (sp == 0);
  assign lifo_dout  = (sp > 0) ? stack_mem[sp-1] : '0;

  always @(posedge clk) begin
    if (lifo_clr) sp <= 0;
    else if (lifo_ren) sp <= sp - 1;
    else if (push_en) begin
      stack_mem[sp] <= push_data;
      sp <= sp + 1;
    end
  end

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q [$];
  int            n_vec = 0;
  int            n_bad = 0;
  int            ncyc = 0;
  int            pops_seen, words_seen, done_seen;
  int            first_ren, first_valid, done_cyc;
  int            burst_t0;
  int            exp_n;
  logic          exp_under;
  logic          last_ren;
  logic          hold_v = 1'b0;
  logic [BW-1:0] hold_d;
  logic          hold_l;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, return just after the rising edge
  task automatic cyc();
    beat_t b;
    @(negedge clk);
    ncyc++;
    last_ren = lifo_ren;
    if (lifo_ren) begin
      pops_seen++;
      if (first_ren < 0) first_ren = ncyc;
    end
    if (out_valid && first_valid < 0) first_valid = ncyc;
    if (done) begin
      done_seen++;
      done_cyc = ncyc;
    end
    if (hold_v && !rst) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_data", int'(out_data), int'(hold_d));
      chk("hold_last", int'(out_last), int'(hold_l));
    end
    hold_v = out_valid && !out_ready && !rst;
    hold_d = out_data;
    hold_l = out_last;
    if (out_valid && out_ready) begin
      words_seen++;
      if (exp_q.size() == 0) begin
        chk("extra_word", 1, 0);
      end else begin
        b = exp_q.pop_front();
        chk("data", int'(out_data), int'(b.data));
        chk("last", int'(out_last), int'(b.last));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int v);
    push_en   = 1'b1;
    push_data = BW'(v);
    cyc();
    push_en   = 1'b0;
  endtask

  task automatic clear_lifo();
    lifo_clr = 1'b1;
    cyc();
    lifo_clr = 1'b0;
  endtask

  // Expected words are the current stack read top-down
  task automatic prep(input int l);
    beat_t b;
    int avail;
    avail = sp;
    exp_n = (l < avail) ? l : avail;
    exp_under = (l > avail);
    for (int i = 0; i < exp_n; i++) begin
      b.data = stack_mem[sp-1-i];
      b.last = (i == l-1);
      exp_q.push_back(b);
    end
    pops_seen = 0; words_seen = 0; done_seen = 0;
    first_ren = -1; first_valid = -1; done_cyc = -1;
  endtask

  task automatic burst(input int l, input int hold);
    prep(l);
    start = 1'b1;
    len = (DP+1)'(l);
    out_ready = (hold == 0);
    cyc();
    burst_t0 = ncyc;
    start = 1'b0;
    for (int i = 0; i < hold; i++) begin
      start = (i == 1);
      len = (DP+1)'(1);
      cyc();
    end
    start = 1'b0;
    if (hold > 0) begin
      chk("bp_pops", pops_seen, 2);
      chk("bp_ren_low", int'(last_ren), 0);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 200 && done_seen == 0; k++) cyc();
    if (done_seen == 0) chk("done_timeout", 0, 1);
    cyc();
    cyc();
    chk("done_count", done_seen, 1);
    chk("words", words_seen, exp_n);
    chk("exp_left", exp_q.size(), 0);
    chk("underrun", int'(underrun), int'(exp_under));
    chk("busy_end", int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; out_ready = 1'b1;
    lifo_clr = 1'b0; push_en = 1'b0; push_data = '0;
    cyc();
    cyc();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_ren", int'(lifo_ren), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_last", int'(out_last), 0);
    rst = 1'b0;
    cyc();

    // basic burst with latency checks
    clear_lifo();
    push_word(3); push_word(7); push_word(9);
    burst(3, 0);
    chk("lat_ren", first_ren, burst_t0 + 1);
    chk("lat_valid", first_valid, burst_t0 + 2);
    chk("lat_done", done_cyc, burst_t0 + 5);

    // underrun: only two words available
    clear_lifo();
    push_word(12); push_word(21);
    burst(5, 0);

    // zero length: clears the sticky underrun, no pops, no output
    burst(0, 0);
    chk("zero_pops", pops_seen, 0);
    chk("zero_valid", first_valid, -1);
    chk("zero_done", done_cyc, burst_t0 + 1);

    // backpressure with an ignored start while busy
    clear_lifo();
    push_word(17); push_word(5); push_word(30); push_word(8); push_word(19);
    burst(4, 5);

    // reset mid-burst
    clear_lifo();
    for (int i = 0; i < 8; i++) push_word(10 + i);
    prep(8);
    start = 1'b1; len = (DP+1)'(8); out_ready = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 50 && words_seen < 2; k++) cyc();
    chk("mid_words", words_seen, 2);
    rst = 1'b1;
    exp_q.delete();
    cyc();
    rst = 1'b0;
    chk("mid_busy", int'(busy), 0);
    chk("mid_done", int'(done), 0);
    chk("mid_underrun", int'(underrun), 0);
    chk("mid_ren", int'(lifo_ren), 0);
    chk("mid_valid", int'(out_valid), 0);
    chk("mid_data", int'(out_data), 0);
    chk("mid_last", int'(out_last), 0);
    done_seen = 0;
    cyc(); cyc(); cyc();
    chk("mid_no_done", done_seen, 0);
    burst(1, 0);

    // full drain
    clear_lifo();
    for (int i = 0; i < 16; i++) push_word((i * 7 + 3) % 32);
    burst(16, 0);
    chk("full_empty", int'(lifo_empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
